// File: rtl/priority_dispatch_pkg.sv
// Shared constants for priority_dispatch: per-lane state encoding and a
// constant log2 helper used to validate the lane index width.
package priority_dispatch_pkg;

  localparam logic [0:0] LANE_EMPTY = 1'b0;
  localparam logic [0:0] LANE_FULL  = 1'b1;

  // Smallest index width able to address n lanes, never below 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int b = 1; b < 32; b++) begin
      if ((1 << b) < n) r = b + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_dispatch_lsb_onehot.sv
// Combinational lowest-set-bit isolator with a one-hot to index encoder.
module priority_dispatch_lsb_onehot
  import priority_dispatch_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int LANE_BITS = 3
) (
  input  logic [WIDTH-1:0]     i_vec,
  output logic [WIDTH-1:0]     o_onehot,
  output logic [LANE_BITS-1:0] o_index
);

  assign o_onehot = i_vec & ~(i_vec - WIDTH'(1));

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    o_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (o_onehot[i]) o_index = o_index | LANE_BITS'(i);
    end
  end

endmodule

// File: rtl/priority_dispatch.sv
// Fans a single valid/ready stream out to WIDTH one-entry lane registers,
// always choosing the lowest-indexed enabled lane that is free this cycle.
module priority_dispatch
  import priority_dispatch_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int DAT_WIDTH = 8,
  parameter int LANE_BITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           lane_en,
  input  logic [DAT_WIDTH-1:0]       in_dat,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH*DAT_WIDTH-1:0] out_dat,
  output logic [WIDTH-1:0]           out_valid,
  input  logic [WIDTH-1:0]           out_ready,
  output logic [LANE_BITS-1:0]       last_lane,
  output logic [15:0]                accept_cnt
);

  if (LANE_BITS < clog2_min1(WIDTH)) begin : g_bad_lane_bits
    $error("priority_dispatch: LANE_BITS too small for WIDTH");
  end

  logic [WIDTH-1:0]     w_valid;
  logic [WIDTH-1:0]     w_free;
  logic [WIDTH-1:0]     w_target;
  logic [LANE_BITS-1:0] w_target_idx;
  logic                 w_accept;
  logic [LANE_BITS-1:0] r_last_lane;
  logic [15:0]          r_accept_cnt;

  // A lane is free if enabled and either empty or emptying this cycle.
  assign w_free   = lane_en & (~w_valid | out_ready);
  assign in_ready = |w_free;
  assign w_accept = in_valid & in_ready & ~rst;

  priority_dispatch_lsb_onehot #(
    .WIDTH     (WIDTH),
    .LANE_BITS (LANE_BITS)
  ) u_lsb_onehot (
    .i_vec    (w_free),
    .o_onehot (w_target),
    .o_index  (w_target_idx)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [0:0]           r_state;
    logic [DAT_WIDTH-1:0] r_dat;
    logic                 w_load;
    logic                 w_drain;

    assign w_load  = w_accept & w_target[i];
    assign w_drain = (r_state == LANE_FULL) & out_ready[i];

    // NOTE: sequential state uses non-blocking assignments so all lanes update from pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= LANE_EMPTY;
        // NOTE: the data register is reset too, so out_dat reads zero after reset.
        r_dat   <= '0;
      end else if (w_load) begin
        r_state <= LANE_FULL;
        r_dat   <= in_dat;
      end else if (w_drain) begin
        r_state <= LANE_EMPTY;
      end
    end

    assign w_valid[i]                           = (r_state == LANE_FULL);
    assign out_dat[i*DAT_WIDTH +: DAT_WIDTH] = r_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lane  <= '0;
      r_accept_cnt <= '0;
    end else if (w_accept) begin
      r_last_lane  <= w_target_idx;
      r_accept_cnt <= r_accept_cnt + 16'd1;
    end
  end

  assign out_valid  = w_valid;
  assign last_lane  = r_last_lane;
  assign accept_cnt = r_accept_cnt;

endmodule
